// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder and its storage array.
// Latency: not applicable (types, constants and a pure function only).
// Backpressure: not applicable.
package dmem_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Replace only the byte lanes whose enable bit is set.
    function automatic logic [WORD_W-1:0] byte_merge(
        input logic [WORD_W-1:0] old_word,
        input logic [WORD_W-1:0] new_word,
        input logic [BE_W-1:0]   wen
    );
        logic [WORD_W-1:0] res;
        res = old_word;
        for (int i = 0; i < BE_W; i++) begin
            if (wen[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage: port A read-first with byte-enabled write, port B registered read-only.
// Latency: port A read is combinational (sampled by the caller on the write edge); port B is 1 cycle.
// Backpressure: none; both ports are serviced every cycle.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic              a_we,
    input  logic [BE_W-1:0]   a_wen,
    input  logic [WORD_W-1:0] a_wdata,
    output logic [WORD_W-1:0] a_rdata,
    input  logic [ADDR_W-1:0] b_addr,
    output logic [WORD_W-1:0] b_rdata
);

    logic [WORD_W-1:0] mem [0:(1<<ADDR_W)-1];

    // The old word is visible until the write edge, so the caller captures it read-first.
    assign a_rdata = mem[a_addr];

    // Storage contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (a_we) begin
            mem[a_addr] <= byte_merge(mem[a_addr], a_wdata, a_wen);
        end
    end

    // Display read samples the pre-write word when port A writes the same location.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            b_rdata <= '0;
        end else begin
            b_rdata <= mem[b_addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: one load/store at a time, read-first response; DMEM_WAIT_EN adds WAIT_CYCLES wait states.
// Latency: commit and resp_valid one cycle after acceptance (plus WAIT_CYCLES when DMEM_WAIT_EN is defined).
// Backpressure: response held stable in RESP until resp_ready; req_ready stays low until the response is taken.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    input  logic [31:0] dbg_addr,
    output logic [31:0] dbg_rdata
);

    state_t            state;
    state_t            state_nxt;
    logic              held;
    logic              held_nxt;
    logic [BE_W-1:0]   lat_wen;
    logic [ADDR_W-1:0] lat_idx;
    logic [WORD_W-1:0] lat_wdata;
    logic [WORD_W-1:0] arr_rdata;
    logic              accept;
    logic              commit;

    // Only the word-index bits take part in addressing; the rest alias away.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, req_addr[31:ADDR_W+2], req_addr[1:0],
                                dbg_addr[31:ADDR_W+2], dbg_addr[1:0]};

    assign accept     = (state == IDLE) && req_ready && req_valid;
    assign commit     = (state != RESP) && (state_nxt == RESP);
    assign resp_valid = (state == RESP);

`ifdef DMEM_WAIT_EN
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);
    logic [3:0] cnt;

    // Wait-state down-counter: loaded on acceptance, counts down only while in WAIT.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= 4'd0;
        end else if (accept) begin
            cnt <= WAIT_LD;
        end else if (state == WAIT) begin
            cnt <= cnt - 4'd1;
        end
    end
`else
    logic [3:0] unused_wait;
    assign unused_wait = 4'(WAIT_CYCLES);
`endif

    // Next state: the request latch is the pipeline stage between acceptance and commit.
    always_comb begin
        state_nxt = state;
        held_nxt  = held;
        case (state)
            IDLE: begin
                if (held) begin
                    held_nxt = 1'b0;
`ifdef DMEM_WAIT_EN
                    state_nxt = (cnt != 4'd0) ? WAIT : RESP;
`else
                    state_nxt = RESP;
`endif
                end else if (accept) begin
                    held_nxt = 1'b1;
                end
            end
            WAIT: begin
`ifdef DMEM_WAIT_EN
                if (cnt == 4'd1) begin
                    state_nxt = RESP;
                end
`else
                state_nxt = IDLE;
`endif
            end
            RESP: begin
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, latch flag and registered ready; ready comes up one edge after reset release.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            held      <= 1'b0;
            req_ready <= 1'b0;
        end else begin
            state     <= state_nxt;
            held      <= held_nxt;
            req_ready <= (state_nxt == IDLE) && !held_nxt;
        end
    end

    // Request latch: captured once per accepted request.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lat_wen   <= '0;
            lat_idx   <= '0;
            lat_wdata <= '0;
        end else if (accept) begin
            lat_wen   <= req_wen;
            lat_idx   <= req_addr[ADDR_W+1:2];
            lat_wdata <= req_wdata;
        end
    end

    // Response register: old word captured on the commit edge, held through RESP.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            resp_rdata <= '0;
        end else if (commit) begin
            resp_rdata <= arr_rdata;
        end
    end

    dmem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .resetn  (resetn),
        .a_addr  (lat_idx),
        .a_we    (commit),
        .a_wen   (lat_wen),
        .a_wdata (lat_wdata),
        .a_rdata (arr_rdata),
        .b_addr  (dbg_addr[ADDR_W+1:2]),
        .b_rdata (dbg_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: expected read-first data queued at acceptance, checked at response.
// Latency: checks resp_valid arrival against 1 (+WAIT_CYCLES when DMEM_WAIT_EN is defined).
// Backpressure: holds resp_ready low to check response stability and request blocking.
module tb_dmem_responder;

    localparam int ADDR_W      = 8;
    localparam int WAIT_CYCLES = 3;
`ifdef DMEM_WAIT_EN
    localparam int LAT = 1 + WAIT_CYCLES;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_wen = 4'h0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic [31:0] dbg_addr = 32'h0;
    logic [31:0] dbg_rdata;

    always #5 clk = ~clk;

    dmem_responder #(
        .ADDR_W      (ADDR_W),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wen    (req_wen),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .dbg_addr   (dbg_addr),
        .dbg_rdata  (dbg_rdata)
    );

    typedef struct {
        logic [31:0] data;
        bit          known;
    } exp_t;

    logic [31:0] model [0:(1<<ADDR_W)-1];
    bit          known [0:(1<<ADDR_W)-1];
    exp_t        sb [$];
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present a request, wait for acceptance, queue the read-first expectation and update the model.
    task automatic send(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata,
                        input string tag);
        int   n;
        int   idx;
        exp_t e;
        req_valid = 1'b1;
        req_wen   = wen;
        req_addr  = addr;
        req_wdata = wdata;
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) check_val({tag, "_accept_timeout"}, 32'(req_ready), 32'd1);
        idx     = int'(addr[ADDR_W+1:2]);
        e.data  = model[idx];
        e.known = known[idx];
        sb.push_back(e);
        for (int b = 0; b < 4; b++) begin
            if (wen[b]) model[idx][8*b +: 8] = wdata[8*b +: 8];
        end
        if (wen == 4'hF) known[idx] = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_wen   = 4'h0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
    endtask

    // Count cycles from acceptance to resp_valid; req_ready must stay low meanwhile.
    task automatic wait_resp(input string tag);
        int k;
        bit rdy_low;
        k = 0;
        rdy_low = 1'b1;
        while (!resp_valid && k < LAT + 20) begin
            if (req_ready) rdy_low = 1'b0;
            @(posedge clk); #1;
            k++;
        end
        check_val({tag, "_latency"}, 32'(k), 32'(LAT));
        check_val({tag, "_ready_low"}, 32'(rdy_low), 32'd1);
    endtask

    // Handshake the response and compare against the scoreboard head.
    task automatic take_resp(input string tag);
        logic [31:0] got;
        exp_t        e;
        got = resp_rdata;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check_val({tag, "_valid_drop"}, 32'(resp_valid), 32'd0);
        if (sb.size() == 0) begin
            check_val({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            if (e.known) check_val({tag, "_rdata"}, got, e.data);
        end
    endtask

    initial begin
        logic [31:0] saved;
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            model[i] = 32'h0;
            known[i] = 1'b0;
        end

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_req_ready", 32'(req_ready), 32'd0);
        check_val("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_val("rst_resp_rdata", resp_rdata, 32'h0);
        check_val("rst_dbg_rdata", dbg_rdata, 32'h0);
        resetn = 1'b1;
        #2;
        check_val("ready_before_edge", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        check_val("ready_after_edge", 32'(req_ready), 32'd1);

        // Full store then load
        send(4'hF, 32'h10, 32'h12345678, "st10");
        wait_resp("st10");
        take_resp("st10");
        send(4'h0, 32'h10, 32'h0, "ld10");
        wait_resp("ld10");
        take_resp("ld10");

        // Partial store then load
        send(4'b0101, 32'h10, 32'hAABBCCDD, "pst10");
        wait_resp("pst10");
        take_resp("pst10");
        send(4'h0, 32'h10, 32'h0, "ld10b");
        wait_resp("ld10b");
        check_val("ld10b_const", resp_rdata, 32'h12BB56DD);
        take_resp("ld10b");

        // Display port returns the old word on the commit edge, new word after
        dbg_addr = 32'h10;
        send(4'hF, 32'h10, 32'h0BADCAFE, "st10c");
        wait_resp("st10c");
        check_val("dbg_read_first", dbg_rdata, 32'h12BB56DD);
        take_resp("st10c");
        check_val("dbg_after_write", dbg_rdata, 32'h0BADCAFE);

        // Load with wait-state latency
        send(4'h0, 32'h20, 32'h0, "ld20");
        wait_resp("ld20");
        take_resp("ld20");

        // Back-pressure: response stable, new request blocked, accepted on the edge after handshake
        send(4'hF, 32'h40, 32'hDEADBEEF, "st40");
        wait_resp("st40");
        take_resp("st40");
        send(4'h0, 32'h40, 32'h0, "ld40bp");
        wait_resp("ld40bp");
        req_valid = 1'b1;
        req_wen   = 4'hF;
        req_addr  = 32'h44;
        req_wdata = 32'h55AA55AA;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_val("bp_valid", 32'(resp_valid), 32'd1);
            check_val("bp_rdata", resp_rdata, 32'hDEADBEEF);
            check_val("bp_ready", 32'(req_ready), 32'd0);
        end
        take_resp("ld40bp");
        check_val("bp_ready_after", 32'(req_ready), 32'd1);
        send(4'hF, 32'h44, 32'h55AA55AA, "st44");
        check_val("st44_accepted", 32'(req_ready), 32'd0);
        wait_resp("st44");
        take_resp("st44");
        send(4'h0, 32'h44, 32'h0, "ld44");
        wait_resp("ld44");
        take_resp("ld44");

        // Aliasing and display port
        send(4'hF, 32'h403, 32'hCAFEF00D, "st403");
        wait_resp("st403");
        take_resp("st403");
        dbg_addr = 32'h000;
        @(posedge clk); #1;
        check_val("dbg_alias", dbg_rdata, 32'hCAFEF00D);
        send(4'h0, 32'h800, 32'h0, "ld800");
        wait_resp("ld800");
        check_val("ld800_const", resp_rdata, 32'hCAFEF00D);
        take_resp("ld800");

        // Reset between acceptance and commit discards the store
        send(4'hF, 32'h30, 32'h11111111, "st30");
        wait_resp("st30");
        take_resp("st30");
        saved = model[12];
        send(4'hF, 32'h30, 32'h22222222, "st30x");
        resetn = 1'b0;
        #1;
        check_val("midrst_req_ready", 32'(req_ready), 32'd0);
        check_val("midrst_resp_valid", 32'(resp_valid), 32'd0);
        check_val("midrst_resp_rdata", resp_rdata, 32'h0);
        check_val("midrst_dbg_rdata", dbg_rdata, 32'h0);
        model[12] = saved;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        check_val("midrst_ready_back", 32'(req_ready), 32'd1);
        send(4'h0, 32'h30, 32'h0, "ld30");
        wait_resp("ld30");
        check_val("ld30_const", resp_rdata, 32'h11111111);
        take_resp("ld30");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

- Data-memory responder for the MEM stage of the five-stage CPU. It accepts one load/store request at a time over a valid/ready handshake and applies byte-enabled writes to a word array. It returns read data over a valid/ready response channel, with optional wait states.
- It also serves a read-only display port for the board debug view.
- It sits between the MEM stage request signals (address, byte write enables, write data) and the storage array. It replaces direct use of the synchronous data RAM so that multi-cycle memory timing can be exercised.

## Interface
- ADDR_W, 8, word-index width; the word index is req_addr[ADDR_W+1:2] and the array holds 2^ADDR_W words.
- WAIT_CYCLES, 2, extra wait states per request; only used when DMEM_WAIT_EN is defined; legal range 0..15.
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk  in  1  clock, rising edge.
  - resetn  in  1  asynchronous, active-low reset.
- Request channel:
  - req_valid  in  1  request present.
  - req_ready  out  1  responder can accept a request.
  - req_wen  in  4  byte write enables; 0 = load; bit i writes bits [8i+7:8i].
  - req_addr  in  32  byte address.
  - req_wdata  in  32  store data.
- Response channel:
  - resp_valid  out  1  response present (issued for loads and stores).
  - resp_ready  in  1  requester accepts the response.
  - resp_rdata  out  32  word at the addressed location before the write (read-first).
- Display port:
  - dbg_addr  in  32  display byte address.
  - dbg_rdata  out  32  display word, registered.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - A request is accepted on req_valid&req_ready. It latches wen, word index and wdata.
  - Next state is WAIT if the wait count is >0, else RESP.
- WAIT:
  - req_ready=0.
  - The down-counter is loaded with WAIT_CYCLES on acceptance and decrements once per cycle.
  - The state moves to RESP on the edge where the counter equals 1.
- Commit edge (transition into RESP):
  - resp_rdata captures the old array word.
  - The array word is then merged with the latched wdata under the latched wen.
  - Bytes with wen=0 are unchanged.
- RESP:
  - resp_valid=1 and resp_rdata is held stable.
  - On resp_valid&resp_ready the state returns to IDLE.
  - resp_valid and resp_rdata must not change while resp_ready=0.
- Address handling:
  - req_addr[1:0] is ignored.
  - Bits above ADDR_W+1 are ignored, so addresses alias modulo 2^(ADDR_W+2).
- Display port:
  - dbg_rdata is updated every cycle from dbg_addr[ADDR_W+1:2].
  - If the same word is written on that edge, the old value is returned.
- Reset:
  - Values while resetn is low: state=IDLE, req_ready=0, resp_valid=0, resp_rdata=0, dbg_rdata=0, counter=0.
  - req_ready is registered and rises on the first clk edge after resetn deasserts.
  - Array contents are not reset.
- Reset mid-operation:
  - If reset is asserted in WAIT, the pending store is discarded; the array is untouched.
  - If reset is asserted in RESP, the already-committed write remains.

## Timing
- Without DMEM_WAIT_EN:
  - A request accepted at edge N gives the commit at edge N+1.
  - resp_valid is high from edge N+1.
- With DMEM_WAIT_EN:
  - The commit happens at edge N+1+WAIT_CYCLES.
  - WAIT_CYCLES=0 is cycle-identical to the build without the macro.
- Throughput:
  - A response handshake at edge M returns to IDLE.
  - The earliest next acceptance is edge M+1.
  - Minimum is one request per 3 cycles without the macro, and 3+WAIT_CYCLES cycles with it.
- dbg_rdata latency: 1 cycle.
- Back-pressure: resp_ready held low keeps the state in RESP indefinitely; req_ready stays 0.

## Configuration
- DMEM_WAIT_EN defined:
  - The WAIT state and the wait counter are compiled in.
  - Latency follows WAIT_CYCLES.
- DMEM_WAIT_EN undefined:
  - No counter and no WAIT state exist.
  - IDLE goes directly to RESP, and WAIT_CYCLES is ignored.

## Structure
- Shared package dmem_pkg holds:
  - State encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2).
  - WORD_W=32 and BE_W=4.
  - The byte-merge function.
- Sub-module dmem_array holds:
  - The 2^ADDR_W x 32 storage.
  - Port A: read-first, byte-enabled write, controlled by the FSM.
  - Port B: read-only registered port for the display.
- dmem_responder itself contains the FSM, request latch, counter and response register.

## Test plan
- Reset, then store at 0x10 (wen=4'hF, wdata=0x12345678), then load at 0x10:
  - The store response returns the old word.
  - The load returns 0x12345678; without the macro, resp_valid rises 1 cycle after acceptance.
- Partial store:
  - Stimulus: word 0x10 = 0x12345678, store wen=4'b0101 with wdata=0xAABBCCDD.
  - Required: a later load returns 0x12BB56DD.
- DMEM_WAIT_EN with WAIT_CYCLES=3:
  - Stimulus: load from 0x20.
  - Required: resp_valid rises exactly 4 cycles after acceptance; req_ready=0 throughout.
- Back-pressure:
  - Stimulus: hold resp_ready=0 for 5 cycles.
  - Required: resp_rdata is stable and req_valid is ignored; after the handshake, the next request is accepted at the following edge.
- Aliasing and display port:
  - Stimulus: store 0xCAFEF00D to address 0x403 with ADDR_W=8, then set dbg_addr=0x000.
  - Required: dbg_rdata=0xCAFEF00D one cycle later.
- Reset mid-operation:
  - Stimulus: assert resetn=0 during WAIT of a store to 0x30 that held 0x11111111.
  - Required: outputs clear immediately; a load after reset returns 0x11111111.
